data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of data words and addresses.
REQ-002 Parameter SETS, 64, number of direct-mapped lines (power of two).
REQ-003 Parameter LINE_WORDS, 4, words per line (power of two).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid_m  input  1  memory-stage load or store present.
REQ-007 write_en_m  input  1  1 = store, 0 = load; qualified by req_valid_m.
REQ-008 addr_m  input  DATA_WIDTH  byte address, word aligned.
REQ-009 wdata_m  input  DATA_WIDTH  store data.
REQ-010 byte_en_m  input  DATA_WIDTH/8  store byte enables.
REQ-011 rdata_m  output  DATA_WIDTH  load data to the pipeline (feeds ReadData_m).
REQ-012 stall_o  output  1  1 = pipeline must hold; pipeline register enables are driven by its inverse.
REQ-013 mem_req_o, mem_we_o  output  1 each  backing-memory request and write qualifier.
REQ-014 mem_addr_o  output  DATA_WIDTH; mem_wdata_o  output  DATA_WIDTH; mem_be_o  output  DATA_WIDTH/8.
REQ-015 mem_ack_i  input  1  memory completes the current request this cycle.
REQ-016 mem_rdata_i  input  DATA_WIDTH  read data, valid when mem_ack_i is high.

Function
REQ-017 Address split SHALL be: byte offset [1:0], word [3:2], index [9:4], tag [31:10] at default parameters; it scales with log2 of the parameters.
REQ-018 FSM states SHALL be IDLE, REFILL, WRITE, DONE.
REQ-019 In IDLE, a load hit (valid and tag match) SHALL return rdata_m combinationally in the same cycle, with stall_o = 0, and the state SHALL remain IDLE.
REQ-020 In IDLE, a load miss SHALL assert stall_o combinationally, and the next state SHALL be REFILL with word counter = 0.
REQ-021 In IDLE, any store SHALL assert stall_o combinationally, and the next state SHALL be WRITE (write-through, no-write-allocate).
REQ-022 In REFILL, the block SHALL issue LINE_WORDS word reads in order 0..LINE_WORDS-1 to {tag,index,counter,2'b00}.
REQ-023 In REFILL, mem_req_o SHALL be held high with stable address until mem_ack_i; on each ack the word is written to the line and the counter increments.
REQ-024 On the last REFILL ack, the block SHALL set the tag and valid bit, and the next state SHALL be DONE.
REQ-025 In WRITE, the block SHALL issue mem_req_o = mem_we_o = 1 with addr_m, wdata_m and byte_en_m until mem_ack_i.
REQ-026 On the WRITE ack, if the line hits, the cached word SHALL be updated per byte enable, and the next state SHALL be DONE.
REQ-027 In DONE, stall_o SHALL be 0, rdata_m SHALL be the addressed cached word, and the next state SHALL be IDLE unconditionally, so a held request is consumed exactly once.
REQ-028 stall_o SHALL be 1 in REFILL and WRITE, including the cycle of the final ack.
REQ-029 mem_req_o SHALL be 0 in IDLE and DONE; memory outputs are don't-care when mem_req_o = 0.
REQ-030 mem_ack_i while mem_req_o = 0 SHALL be ignored.
REQ-031 Counter wrap at LINE_WORDS-1 SHALL coincide with the DONE transition; the counter SHALL never reach LINE_WORDS.
REQ-032 When req_valid_m = 0, rdata_m SHALL be 0 and stall_o SHALL be 0 (IDLE).

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, counter 0, all valid bits 0, stall_o 0, mem_req_o 0, mem_we_o 0.
REQ-034 Reset during REFILL or WRITE SHALL abandon the transaction; the partially filled line SHALL remain invalid; the memory SHALL tolerate a dropped request.
REQ-035 Data and tag arrays SHALL NOT require reset.

Structure
REQ-036 Shared package cache_pkg SHALL hold the state enum and the derived localparams for offset, word, index and tag widths.
REQ-037 Data and tag storage SHALL be one sub-module, dcache_line_store, with one read port and one byte-enabled write port.

Verification
REQ-038 Reset, then load 0x0000_0040 with memory returning 0x11,0x22,0x33,0x44 (1-cycle acks) -> stall_o high 5 cycles; DONE rdata_m = 0x11; next load 0x44 hits with stall_o 0 and data 0x22.
REQ-039 Store 0xDEADBEEF, byte_en 4'b0011 to cached 0x40 -> one write request; after ack, load 0x40 returns 0x1111BEEF when old data = 0x11111111.
REQ-040 Store to uncached 0x1000 -> write request issued; subsequent load 0x1000 misses (no allocate).
REQ-041 Load 0x0000_0040 then 0x0000_0440 (same index, different tag) -> second refill evicts; reload of 0x40 misses again.
REQ-042 Assert rst_n low after the 2nd REFILL ack -> mem_req_o drops immediately; after release, the same load misses and refills all 4 words.
REQ-043 Memory ack delayed 3 cycles per word -> mem_addr_o is stable while waiting, and stall_o is held throughout.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-field widths for the data cache
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SETS       = 64;
    localparam int DEF_LINE_WORDS = 4;

    // Field widths as a function of the geometry; the top calls these with its own parameters
    function automatic int offset_w(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int word_w(input int lw);
        return $clog2(lw);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int dw, input int sets, input int lw);
        return dw - offset_w(dw) - word_w(lw) - index_w(sets);
    endfunction

    localparam int OFFSET_W = offset_w(DEF_DATA_WIDTH);
    localparam int WORD_W   = word_w(DEF_LINE_WORDS);
    localparam int INDEX_W  = index_w(DEF_SETS);
    localparam int TAG_W    = tag_w(DEF_DATA_WIDTH, DEF_SETS, DEF_LINE_WORDS);

endpackage

// File: rtl/dcache_line_store.sv
// rtl/dcache_line_store.sv - data and tag arrays, one async read port, one byte-enabled write port
module dcache_line_store #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 22
) (
    input  logic                         clk,
    input  logic [$clog2(SETS)-1:0]      rd_index,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [TAG_W-1:0]             rd_tag,
    input  logic                         wr_en,
    input  logic [$clog2(SETS)-1:0]      wr_index,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
    input  logic [DATA_WIDTH/8-1:0]      wr_be,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         tag_we,
    input  logic [TAG_W-1:0]             tag_data
);

    logic [DATA_WIDTH-1:0] data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0]      tag_mem  [SETS];

    assign rd_data = data_mem[{rd_index, rd_word}];
    assign rd_tag  = tag_mem[rd_index];

    // Byte-lane write into the addressed word; contents are meaningless until the valid bit says otherwise
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wr_be[b]) begin
                    data_mem[{wr_index, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Tag is written once, when the last word of a refill lands
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_index] <= tag_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through, no-write-allocate data cache for the memory stage
module data_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_m,
    input  logic                    write_en_m,
    input  logic [DATA_WIDTH-1:0]   addr_m,
    input  logic [DATA_WIDTH-1:0]   wdata_m,
    input  logic [DATA_WIDTH/8-1:0] byte_en_m,
    output logic [DATA_WIDTH-1:0]   rdata_m,
    output logic                    stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic                    mem_ack_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int OFF_W = offset_w(DATA_WIDTH);
    localparam int WRD_W = word_w(LINE_WORDS);
    localparam int IDX_W = index_w(SETS);
    localparam int TG_W  = tag_w(DATA_WIDTH, SETS, LINE_WORDS);
    localparam int BE_W  = DATA_WIDTH / 8;

    state_t state_q, state_d;
    logic [WRD_W-1:0] count_q;
    logic [SETS-1:0]  valid_q;

    logic [WRD_W-1:0] addr_word;
    logic [IDX_W-1:0] addr_index;
    logic [TG_W-1:0]  addr_tag;
    logic             unused_offset;

    logic [DATA_WIDTH-1:0] rd_data;
    logic [TG_W-1:0]       rd_tag;
    logic                  hit;
    logic                  is_last;

    logic             wr_en;
    logic [WRD_W-1:0] wr_word;
    logic [BE_W-1:0]  wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic             tag_we;
    logic             stall_raw;
    logic             req_raw;
    logic             we_raw;

    assign addr_word     = addr_m[OFF_W +: WRD_W];
    assign addr_index    = addr_m[OFF_W + WRD_W +: IDX_W];
    assign addr_tag      = addr_m[DATA_WIDTH-1 -: TG_W];
    assign unused_offset = ^addr_m[OFF_W-1:0];

    assign hit     = valid_q[addr_index] && (rd_tag == addr_tag);
    assign is_last = (count_q == WRD_W'(LINE_WORDS - 1));

    dcache_line_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TG_W)
    ) u_store (
        .clk      (clk),
        .rd_index (addr_index),
        .rd_word  (addr_word),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .wr_en    (wr_en),
        .wr_index (addr_index),
        .wr_word  (wr_word),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .tag_we   (tag_we),
        .tag_data (addr_tag)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Refill word counter and per-line valid bits; a line is invalid from miss detection until its last word lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            valid_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_q <= '0;
                    if (req_valid_m && !write_en_m && !hit) begin
                        valid_q[addr_index] <= 1'b0;
                    end
                end
                ST_REFILL: begin
                    if (mem_ack_i) begin
                        count_q <= is_last ? '0 : count_q + 1'b1;
                        if (is_last) begin
                            valid_q[addr_index] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic; DONE always returns to IDLE so a held request is serviced once
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_m) begin
                    if (write_en_m)  state_d = ST_WRITE;
                    else if (!hit)   state_d = ST_REFILL;
                end
            end
            ST_REFILL: if (mem_ack_i && is_last) state_d = ST_DONE;
            ST_WRITE:  if (mem_ack_i)            state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs: pipeline stall/data, memory request, and line-store write port
    always_comb begin
        stall_raw   = 1'b0;
        req_raw     = 1'b0;
        we_raw      = 1'b0;
        rdata_m     = '0;
        mem_addr_o  = addr_m;
        mem_wdata_o = wdata_m;
        mem_be_o    = byte_en_m;
        wr_en       = 1'b0;
        wr_word     = addr_word;
        wr_be       = byte_en_m;
        wr_data     = wdata_m;
        tag_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_m) begin
                    if (write_en_m || !hit) stall_raw = 1'b1;
                    else                    rdata_m   = rd_data;
                end
            end
            ST_REFILL: begin
                stall_raw   = 1'b1;
                req_raw     = 1'b1;
                mem_addr_o  = {addr_tag, addr_index, count_q, {OFF_W{1'b0}}};
                mem_wdata_o = '0;
                mem_be_o    = '1;
                wr_en       = mem_ack_i;
                wr_word     = count_q;
                wr_be       = '1;
                wr_data     = mem_rdata_i;
                tag_we      = mem_ack_i && is_last;
            end
            ST_WRITE: begin
                stall_raw = 1'b1;
                req_raw   = 1'b1;
                we_raw    = 1'b1;
                wr_en     = mem_ack_i && hit;
            end
            ST_DONE: begin
                if (req_valid_m) rdata_m = rd_data;
            end
            default: ;
        endcase
        stall_o   = rst_n && stall_raw;
        mem_req_o = rst_n && req_raw;
        mem_we_o  = rst_n && we_raw;
    end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed vector bench for data_cache
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_m;
    logic        write_en_m;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    logic [3:0]  byte_en_m;
    logic [31:0] rdata_m;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_cache dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_m (req_valid_m),
        .write_en_m  (write_en_m),
        .addr_m      (addr_m),
        .wdata_m     (wdata_m),
        .byte_en_m   (byte_en_m),
        .rdata_m     (rdata_m),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    // Backing memory: acks after ack_delay waiting cycles, applies byte-enabled writes on ack
    logic [31:0] mem [0:4095];
    int ack_delay = 0;
    int wait_cnt  = 0;

    assign mem_ack_i   = mem_req_o && (wait_cnt == ack_delay);
    assign mem_rdata_i = mem[mem_addr_o[13:2]];

    always @(posedge clk) begin
        if (mem_req_o && !mem_ack_i) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
        if (mem_req_o && mem_ack_i && mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_o[b]) mem[mem_addr_o[13:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request held until stall drops; reports stall cycles, acks, the returned word and protocol checks
    task automatic do_op(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         output int stalls, output int acks, output logic [31:0] rd,
                         output bit addr_ok, output bit stable_ok, output bit timed_out);
        logic [31:0] exp_addr;
        logic [31:0] prev_addr;
        bit          prev_wait;
        stalls = 0; acks = 0; rd = '0;
        addr_ok = 1; stable_ok = 1; timed_out = 1;
        prev_wait = 0; prev_addr = '0;
        @(posedge clk); #1;
        req_valid_m = 1'b1; write_en_m = we; addr_m = a; wdata_m = wd; byte_en_m = be;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (!stall_o) begin
                rd = rdata_m;
                timed_out = 0;
                break;
            end
            stalls++;
            if (prev_wait && (!mem_req_o || mem_addr_o !== prev_addr)) stable_ok = 0;
            prev_wait = mem_req_o && !mem_ack_i;
            prev_addr = mem_addr_o;
            if (mem_ack_i) begin
                if (we) begin
                    if (mem_addr_o !== a || mem_we_o !== 1'b1 || mem_wdata_o !== wd || mem_be_o !== be) addr_ok = 0;
                end else begin
                    exp_addr = (a & ~32'hF) | (32'(acks) << 2);
                    if (mem_addr_o !== exp_addr || mem_we_o !== 1'b0) addr_ok = 0;
                end
                acks++;
            end
        end
        @(posedge clk); #1;
        req_valid_m = 1'b0; write_en_m = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          poke;
        logic [31:0] poke_addr;
        logic [31:0] poke_data;
        int          exp_stall;
        int          exp_acks;
        logic [31:0] exp_rdata;
        bit          chk_rd;
    } vec_t;

    function automatic vec_t ld(input logic [31:0] a, input int s, input int k, input logic [31:0] d);
        vec_t v;
        v.we = 0; v.addr = a; v.wdata = '0; v.be = 4'h0;
        v.poke = 0; v.poke_addr = '0; v.poke_data = '0;
        v.exp_stall = s; v.exp_acks = k; v.exp_rdata = d; v.chk_rd = 1;
        return v;
    endfunction

    function automatic vec_t st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        vec_t v;
        v.we = 1; v.addr = a; v.wdata = d; v.be = be;
        v.poke = 0; v.poke_addr = '0; v.poke_data = '0;
        v.exp_stall = 2; v.exp_acks = 1; v.exp_rdata = '0; v.chk_rd = 0;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        int          s, k;
        logic [31:0] rd;
        bit          aok, sok, tmo;
        int          n;
        string       tag;

        for (int i = 0; i < 4096; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            mem[(32'h40  >> 2) + i] = 32'h11 * (i + 1);
            mem[(32'h440 >> 2) + i] = 32'hA0 + i;
            mem[(32'h80  >> 2) + i] = 32'h8080_0000 + i;
            mem[(32'hC0  >> 2) + i] = 32'hC0C0_0000 + i;
        end

        vecs[0]  = ld(32'h40,   5, 4, 32'h11);
        vecs[1]  = ld(32'h44,   0, 0, 32'h22);
        vecs[2]  = ld(32'h4C,   0, 0, 32'h44);
        vecs[3]  = ld(32'h440,  5, 4, 32'hA0);
        vecs[4]  = ld(32'h40,   5, 4, 32'h11);
        vecs[5]  = ld(32'h448,  5, 4, 32'hA2);
        vecs[5].poke = 1; vecs[5].poke_addr = 32'h40; vecs[5].poke_data = 32'h1111_1111;
        vecs[6]  = ld(32'h40,   5, 4, 32'h1111_1111);
        vecs[7]  = st(32'h40,   32'hDEAD_BEEF, 4'b0011);
        vecs[8]  = ld(32'h40,   0, 0, 32'h1111_BEEF);
        vecs[9]  = ld(32'h44,   0, 0, 32'h22);
        vecs[10] = st(32'h1000, 32'hCAFE_F00D, 4'b1111);
        vecs[11] = ld(32'h1000, 5, 4, 32'hCAFE_F00D);
        vecs[12] = ld(32'h1000, 0, 0, 32'hCAFE_F00D);
        vecs[13] = ld(32'h440,  5, 4, 32'hA0);
        vecs[14] = ld(32'h40,   5, 4, 32'h1111_BEEF);

        // Reset state, with a load miss presented while reset is held
        rst_n = 1'b0; req_valid_m = 1'b1; write_en_m = 1'b0; addr_m = 32'h40;
        wdata_m = '0; byte_en_m = '0;
        #12;
        check("reset_stall",   32'(stall_o),   32'd0);
        check("reset_mem_req", 32'(mem_req_o), 32'd0);
        check("reset_mem_we",  32'(mem_we_o),  32'd0);
        req_valid_m = 1'b0;
        #1;
        check("reset_rdata",   rdata_m,        32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].poke) mem[vecs[i].poke_addr[13:2]] = vecs[i].poke_data;
            do_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, s, k, rd, aok, sok, tmo);
            tag = $sformatf("vec%0d", i);
            check({tag, "_timeout"}, 32'(tmo), 32'd0);
            check({tag, "_stall"},   32'(s),   32'(vecs[i].exp_stall));
            check({tag, "_acks"},    32'(k),   32'(vecs[i].exp_acks));
            if (vecs[i].chk_rd)    check({tag, "_rdata"}, rd, vecs[i].exp_rdata);
            if (vecs[i].exp_acks > 0) check({tag, "_memif"}, 32'(aok), 32'd1);
        end

        // Idle request-free cycle on a cached address returns zero without stall
        req_valid_m = 1'b0; addr_m = 32'h40;
        @(negedge clk);
        check("idle_rdata", rdata_m,      32'd0);
        check("idle_stall", 32'(stall_o), 32'd0);

        // Reset right after the second refill ack abandons the fill
        @(posedge clk); #1;
        req_valid_m = 1'b1; write_en_m = 1'b0; addr_m = 32'h80;
        n = 0;
        for (int cyc = 0; cyc < 50 && n < 2; cyc++) begin
            @(negedge clk);
            if (mem_ack_i) n++;
        end
        check("rst_mid_acks_seen", 32'(n), 32'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mid_stall",   32'(stall_o),   32'd0);
        req_valid_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(1'b0, 32'h80, '0, 4'h0, s, k, rd, aok, sok, tmo);
        check("rst_refill_stall", 32'(s), 32'd5);
        check("rst_refill_acks",  32'(k), 32'd4);
        check("rst_refill_rdata", rd,     32'h8080_0000);
        check("rst_refill_memif", 32'(aok), 32'd1);
        do_op(1'b0, 32'h40, '0, 4'h0, s, k, rd, aok, sok, tmo);
        check("rst_cleared_stall", 32'(s), 32'd5);
        check("rst_cleared_rdata", rd,     32'h1111_BEEF);

        // Slow memory: three wait cycles per word
        ack_delay = 3;
        do_op(1'b0, 32'hC4, '0, 4'h0, s, k, rd, aok, sok, tmo);
        check("slow_timeout", 32'(tmo), 32'd0);
        check("slow_stall",   32'(s),   32'd17);
        check("slow_acks",    32'(k),   32'd4);
        check("slow_rdata",   rd,       32'hC0C0_0001);
        check("slow_memif",   32'(aok), 32'd1);
        check("slow_stable",  32'(sok), 32'd1);
        ack_delay = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
